// File: rtl/leb128_reader.sv
// Fetches one LEB128-encoded 32-bit integer from a byte-wide ROM and returns the value and the address after it.
// Define LEB128_SIGNED_EN to add the is_signed input and sign-extending decode.
module leb128_reader #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
`ifdef LEB128_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [31:0] next_addr,
  output logic        error,
  output logic [31:0] rom_addr,
  output logic        rom_read_en,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;

  // Handshake: rom_read_en holds while rom_addr is valid; a byte is taken only
  // in FETCH on the cycle rom_ready is high, and rom_ready elsewhere is dropped.
  state_t      state;
  logic [31:0] acc;
  logic [2:0]  n;
  logic [3:0]  tcnt;
  logic        accept;
  logic [5:0]  shamt;
  logic [31:0] acc_next;
  logic [31:0] final_value;
  logic        fifth_bad;

`ifdef LEB128_SIGNED_EN
  logic sgn;
`endif

  assign fsm_state = state;
  assign accept    = start && (state == IDLE || state == DONE);

  always_comb begin
    shamt       = {3'd0, n} * 6'd7;
    acc_next    = acc | ({25'd0, rom_data[6:0]} << shamt);
    final_value = acc_next;
`ifdef LEB128_SIGNED_EN
    if (sgn) begin
      fifth_bad = rom_data[7] || !(rom_data[6:3] == 4'h0 || rom_data[6:3] == 4'hF);
      // Sign-extend from the last payload bit when the encoding is shorter than 5 bytes.
      if (rom_data[6] && n < 3'd4)
        final_value = acc_next | (32'hFFFF_FFFF << (shamt + 6'd7));
    end else begin
      fifth_bad = rom_data[7] || (rom_data[6:4] != 3'd0);
    end
`else
    fifth_bad = rom_data[7] || (rom_data[6:4] != 3'd0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rom_read_en <= 1'b0;
      rom_addr    <= 32'd0;
      value       <= 32'd0;
      next_addr   <= 32'd0;
      acc         <= 32'd0;
      n           <= 3'd0;
      tcnt        <= 4'd0;
`ifdef LEB128_SIGNED_EN
      sgn         <= 1'b0;
`endif
    end else if (accept) begin
      state       <= FETCH;
      busy        <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      rom_read_en <= 1'b1;
      rom_addr    <= start_addr;
      acc         <= 32'd0;
      n           <= 3'd0;
      tcnt        <= 4'd0;
`ifdef LEB128_SIGNED_EN
      sgn         <= is_signed;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (rom_ready) begin
            if ((n == 3'd4 && fifth_bad) || !rom_data[7]) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              rom_read_en <= 1'b0;
              rom_addr    <= 32'd0;
              if (n == 3'd4 && fifth_bad) begin
                error     <= 1'b1;
                value     <= 32'd0;
                next_addr <= rom_addr;
              end else begin
                value     <= final_value;
                next_addr <= rom_addr + 32'd1;
              end
            end else begin
              acc      <= acc_next;
              n        <= n + 3'd1;
              rom_addr <= rom_addr + 32'd1;
              tcnt     <= 4'd0;
            end
          end else if (tcnt == 4'(TIMEOUT - 1)) begin
            // Stalled: report the byte we were waiting for.
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            error       <= 1'b1;
            rom_read_en <= 1'b0;
            rom_addr    <= 32'd0;
            value       <= 32'd0;
            next_addr   <= rom_addr;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
